atualiza_linha_fifo: RTL and testbench



---
 rtl/atualiza_linha_fifo_pkg.sv | 29 ++
 rtl/atualiza_linha_fifo_line_fifo.sv | 59 +++++
 rtl/atualiza_linha_fifo.sv | 80 ++++++++
 tb/tb_atualiza_linha_fifo.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/atualiza_linha_fifo_pkg.sv
// Shared constants and types for the time-decayed Bloom-filter line updater.
package atualiza_linha_fifo_pkg;

    function automatic int unsigned ceil_log2(input int unsigned v);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((32'd1 << i) < v) r = i + 1;
        end
        return r;
    endfunction

    localparam int unsigned DATA_WIDTH      = 72;
    localparam int unsigned BUCKET_SZ       = 4;
    localparam int unsigned BLOOM_INIT_POS  = 16;
    localparam int unsigned NUM_BUCKETS     = (DATA_WIDTH - BLOOM_INIT_POS) / BUCKET_SZ;
    localparam int unsigned FIFO_DEPTH_BITS = 3;
    localparam int unsigned BITS_SHIFT      = ceil_log2(NUM_BUCKETS);
    localparam int unsigned LOOP_W          = BLOOM_INIT_POS - BITS_SHIFT;

    // How the head word relates to the current time slot
    typedef enum logic [1:0] {
        UPD_KEEP = 2'd0,   // already marked with the current slot
        UPD_SAME = 2'd1,   // same rotation, slot behind
        UPD_WRAP = 2'd2,   // previous rotation, slot ahead of current
        UPD_ALL  = 2'd3    // stale, ahead or invalid: clear everything
    } upd_case_e;

endpackage

// File: rtl/atualiza_linha_fifo_line_fifo.sv
// Generic fall-through FIFO: head word is visible the cycle after it is written.
module line_fifo #(
    parameter int unsigned WIDTH          = 72,
    parameter int unsigned MAX_DEPTH_BITS = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] din,
    input  logic             wr_en,
    input  logic             rd_en,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             nearly_full,
    output logic             empty
);

    localparam int unsigned DEPTH = 1 << MAX_DEPTH_BITS;
    localparam int unsigned PTR_W = MAX_DEPTH_BITS;
    localparam int unsigned CNT_W = MAX_DEPTH_BITS + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             push;
    logic             pop;

    // A write into a full FIFO is dropped even if a read frees a slot this cycle
    always_comb begin
        push = wr_en && !full;
        pop  = rd_en && !empty;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= PTR_W'(wr_ptr + PTR_W'(1));
            if (pop)  rd_ptr <= PTR_W'(rd_ptr + PTR_W'(1));
            if (push && !pop)      count <= CNT_W'(count + CNT_W'(1));
            else if (pop && !push) count <= CNT_W'(count - CNT_W'(1));
        end
    end

    // Storage is intentionally not reset
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= din;
    end

    always_comb begin
        dout        = mem[rd_ptr];
        full        = (count == CNT_W'(DEPTH));
        nearly_full = (count >= CNT_W'(DEPTH - 1));
        empty       = (count == '0);
    end

endmodule

// File: rtl/atualiza_linha_fifo.sv
// Buffered line updater: FIFO head presented with expired buckets cleared and slot mark refreshed.
module atualiza_linha_fifo
    import atualiza_linha_fifo_pkg::*;
#(
    parameter int unsigned MAX_DEPTH_BITS = FIFO_DEPTH_BITS
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] din,
    input  logic                  wr_en,
    input  logic                  rd_en,
    input  logic [BITS_SHIFT-1:0] cur_bucket,
    input  logic [LOOP_W-1:0]     cur_loop,
    output logic [DATA_WIDTH-1:0] dout,
    output logic [DATA_WIDTH-1:0] raw_dout,
    output logic                  full,
    output logic                  nearly_full,
    output logic                  empty
);

    logic [DATA_WIDTH-1:0]  head;
    logic [BITS_SHIFT-1:0]  s_b;
    logic [LOOP_W-1:0]      s_l;
    upd_case_e              upd;
    logic [NUM_BUCKETS-1:0] clr;

    line_fifo #(
        .WIDTH          (DATA_WIDTH),
        .MAX_DEPTH_BITS (MAX_DEPTH_BITS)
    ) u_fifo (
        .clk         (clk),
        .reset       (reset),
        .din         (din),
        .wr_en       (wr_en),
        .rd_en       (rd_en),
        .dout        (head),
        .full        (full),
        .nearly_full (nearly_full),
        .empty       (empty)
    );

    // Classify the stored mark against the current time slot
    always_comb begin
        s_b = head[BITS_SHIFT-1:0];
        s_l = head[BLOOM_INIT_POS-1:BITS_SHIFT];
        upd = UPD_ALL;
        if ((32'(cur_bucket) >= NUM_BUCKETS) || (32'(s_b) >= NUM_BUCKETS)) begin
            upd = UPD_ALL;
        end else if ((s_l == cur_loop) && (s_b == cur_bucket)) begin
            upd = UPD_KEEP;
        end else if ((s_l == cur_loop) && (s_b < cur_bucket)) begin
            upd = UPD_SAME;
        end else if ((LOOP_W'(s_l + LOOP_W'(1)) == cur_loop) && (s_b > cur_bucket)) begin
            upd = UPD_WRAP;
        end
    end

    // Buckets that expired between the stored slot and the current one
    always_comb begin
        clr = '0;
        for (int unsigned i = 0; i < NUM_BUCKETS; i++) begin
            case (upd)
                UPD_KEEP: clr[i] = 1'b0;
                UPD_SAME: clr[i] = (i > 32'(s_b)) && (i <= 32'(cur_bucket));
                UPD_WRAP: clr[i] = (i > 32'(s_b)) || (i <= 32'(cur_bucket));
                default:  clr[i] = 1'b1;
            endcase
        end
    end

    always_comb begin
        raw_dout = head;
        dout     = head;
        for (int unsigned i = 0; i < NUM_BUCKETS; i++) begin
            if (clr[i]) dout[BLOOM_INIT_POS + i*BUCKET_SZ +: BUCKET_SZ] = '0;
        end
        if (upd != UPD_KEEP) dout[BLOOM_INIT_POS-1:0] = {cur_loop, cur_bucket};
    end

endmodule

// File: tb/tb_atualiza_linha_fifo.sv
// Directed bench for atualiza_linha_fifo: update-rule vector table plus FIFO corner sequences.
module tb_atualiza_linha_fifo;

    logic        clk;
    logic        reset;
    logic [71:0] din;
    logic        wr_en;
    logic        rd_en;
    logic [3:0]  cur_bucket;
    logic [11:0] cur_loop;
    logic [71:0] dout;
    logic [71:0] raw_dout;
    logic        full;
    logic        nearly_full;
    logic        empty;

    int tests;
    int fails;

    typedef struct {
        logic [71:0] din;
        logic [11:0] loop;
        logic [3:0]  bucket;
        logic [71:0] exp;
    } vec_t;

    vec_t vecs[9];

    atualiza_linha_fifo dut (
        .clk         (clk),
        .reset       (reset),
        .din         (din),
        .wr_en       (wr_en),
        .rd_en       (rd_en),
        .cur_bucket  (cur_bucket),
        .cur_loop    (cur_loop),
        .dout        (dout),
        .raw_dout    (raw_dout),
        .full        (full),
        .nearly_full (nearly_full),
        .empty       (empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_flags(input string name, input logic e, input logic nf, input logic f);
        chk({name, " empty"}, 72'(empty), 72'(e));
        chk({name, " nearly_full"}, 72'(nearly_full), 72'(nf));
        chk({name, " full"}, 72'(full), 72'(f));
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [71:0] d);
        din   = d;
        wr_en = 1'b1;
        step();
        wr_en = 1'b0;
    endtask

    task automatic pop();
        rd_en = 1'b1;
        step();
        rd_en = 1'b0;
    endtask

    initial begin
        tests = 0;
        fails = 0;
        vecs[0] = '{72'hFFFFFFFFFFFFFF0000, 12'd0,     4'd3,  72'hFFFFFFFFFF000F0003};
        vecs[1] = '{72'hFFFFFFFFFFFFFF005C, 12'd6,     4'd1,  72'h0FFFFFFFFFFF000061};
        vecs[2] = '{72'hFFFFFFFFFFFFFF0020, 12'd9,     4'd5,  72'h000000000000000095};
        vecs[3] = '{72'hFFFFFFFFFFFFFF0020, 12'd2,     4'd0,  72'hFFFFFFFFFFFFFF0020};
        vecs[4] = '{72'h123456789ABCDE0013, 12'd1,     4'd7,  72'h1234560000BCDE0017};
        vecs[5] = '{72'hFFFFFFFFFFFFFFFFFD, 12'd0,     4'd0,  72'hFFFFFFFFFFFFF00000};
        vecs[6] = '{72'hFFFFFFFFFFFFFF0025, 12'd2,     4'd3,  72'h000000000000000023};
        vecs[7] = '{72'hFFFFFFFFFFFFFF0025, 12'd3,     4'd7,  72'h000000000000000037};
        vecs[8] = '{72'hFFFFFFFFFFFFFF000E, 12'd0,     4'd14, 72'h00000000000000000E};

        reset = 1'b0; din = '0; wr_en = 1'b0; rd_en = 1'b0;
        cur_bucket = '0; cur_loop = '0;
        step();
        step();
        chk_flags("reset", 1'b1, 1'b0, 1'b0);
        reset = 1'b1;
        step();

        // async reset with three entries queued
        push(72'd1); push(72'd2); push(72'd3);
        chk("pre-reset empty", 72'(empty), 72'd0);
        reset = 1'b0;
        #1;
        chk_flags("async reset", 1'b1, 1'b0, 1'b0);
        step();
        reset = 1'b1;
        step();

        // update-rule table
        for (int i = 0; i < 9; i++) begin
            push(vecs[i].din);
            cur_loop   = vecs[i].loop;
            cur_bucket = vecs[i].bucket;
            #1;
            chk($sformatf("vec%0d dout", i), dout, vecs[i].exp);
            chk($sformatf("vec%0d raw", i), raw_dout, vecs[i].din);
            pop();
            chk($sformatf("vec%0d empty", i), 72'(empty), 72'd1);
        end

        // fill past capacity, drain, pop on empty
        for (int i = 1; i <= 9; i++) begin
            push(72'(i));
            if (i == 6) chk_flags("fill6", 1'b0, 1'b0, 1'b0);
            if (i == 7) chk_flags("fill7", 1'b0, 1'b1, 1'b0);
            if (i >= 8) chk_flags($sformatf("fill%0d", i), 1'b0, 1'b1, 1'b1);
        end
        for (int i = 1; i <= 8; i++) begin
            chk($sformatf("drain%0d", i), raw_dout, 72'(i));
            pop();
        end
        chk_flags("drained", 1'b1, 1'b0, 1'b0);
        pop();
        chk_flags("pop on empty", 1'b1, 1'b0, 1'b0);
        push(72'hAB);
        chk("after empty pop", raw_dout, 72'hAB);
        pop();

        // simultaneous read/write when full: write dropped
        for (int i = 0; i < 8; i++) push(72'(10 + i));
        din = 72'd99; wr_en = 1'b1; rd_en = 1'b1;
        step();
        wr_en = 1'b0; rd_en = 1'b0;
        chk_flags("full rw", 1'b0, 1'b1, 1'b0);
        for (int i = 1; i <= 7; i++) begin
            chk($sformatf("full rw drain%0d", i), raw_dout, 72'(10 + i));
            pop();
        end
        chk_flags("full rw drained", 1'b1, 1'b0, 1'b0);

        // simultaneous read/write at count 4
        for (int i = 0; i < 4; i++) push(72'(20 + i));
        din = 72'd24; wr_en = 1'b1; rd_en = 1'b1;
        step();
        wr_en = 1'b0; rd_en = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            chk($sformatf("mid rw drain%0d", i), raw_dout, 72'(20 + i));
            chk($sformatf("mid rw empty%0d", i), 72'(empty), 72'd0);
            pop();
        end
        chk_flags("mid rw drained", 1'b1, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
